// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory block.
package instr_mem_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Wide enough for any practical instruction width; the top slices it to DATA_W.
    localparam logic [63:0] DEFAULT_HALT_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/instr_mem_array.sv
// Word storage with per-entry written marks, one write port and one registered read port.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = DEFAULT_HALT_WORD[DATA_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [DATA_W-1:0] rd_data_p1;

    // Data storage carries no reset; the written marks decide what is visible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            written <= '0;
        end else if (we) begin
            written[waddr] <= 1'b1;
        end
    end

    // ---- read stage p0 -> p1 ----
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data_p1 <= (int'(raddr) < DEPTH && written[raddr]) ? mem[raddr] : HALT_WORD;
        end
    end

    assign rd_data = rd_data_p1;

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory: a LOAD phase filled by a streaming loader, then a RUN phase serving 1-cycle fetches.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = DEFAULT_HALT_WORD[DATA_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              load_done,
    input  logic              reload,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_halt,
    output logic              running,
    output logic [ADDR_W:0]   load_count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   count;
    logic              accept;
    logic              last_word;
    logic              vld_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] rd_data_p1;

    assign load_ready = (state == LOAD) && (count < DEPTH_C);
    assign accept     = load_valid && load_ready;
    assign last_word  = accept && (count == DEPTH_C - 1'b1);

    // reload overrides any same-cycle load activity; a word written then is masked by the cleared marks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            count <= '0;
        end else if (reload) begin
            state <= LOAD;
            count <= '0;
        end else begin
            if (accept) begin
                count <= count + 1'b1;
            end
            if (state == LOAD && (load_done || last_word)) begin
                state <= RUN;
            end
        end
    end

    // ---- fetch stage p0: request qualified by state ----
    assign vld_p0 = (state == RUN) && fetch_req && !reload;

    instr_mem_array #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .HALT_WORD (HALT_WORD)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .clr     (reload),
        .we      (accept),
        .waddr   (count[ADDR_W-1:0]),
        .wdata   (load_data),
        .re      (vld_p0),
        .raddr   (fetch_addr),
        .rd_data (rd_data_p1)
    );

    // ---- fetch stage p1: result presented ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    assign fetch_valid = vld_p1;
    assign fetch_instr = vld_p1 ? rd_data_p1 : HALT_WORD;
    assign fetch_halt  = vld_p1 && (rd_data_p1 == HALT_WORD);
    assign running     = (state == RUN);
    assign load_count  = count;

endmodule

// File: tb/tb_instr_mem.sv
// Scoreboard bench for instr_mem: a reference model queues expected fetch results, a negedge monitor retires them.
module tb_instr_mem;

    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 32;
    localparam int          DATA_W = 32;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              reload;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_halt;
    logic              running;
    logic [ADDR_W:0]   load_count;

    instr_mem #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .HALT_WORD (HALT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .reload      (reload),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_halt  (fetch_halt),
        .running     (running),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [DEPTH];
    int          ref_n;
    bit          ref_run;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fetch(input int a);
        return (a < ref_n) ? ref_mem[a] : HALT;
    endfunction

    // Retire one expected result per valid cycle; any valid without a pending request is an error.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fetch_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(fetch_valid), 64'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("fetch_instr", 64'(fetch_instr), 64'(e));
                    check("fetch_halt", 64'(fetch_halt), 64'(e == HALT));
                end
            end else begin
                if (exp_q.size() != 0) begin
                    check("missing_valid", 64'(fetch_valid), 64'd1);
                    void'(exp_q.pop_front());
                end
                check("idle_instr", 64'(fetch_instr), 64'(HALT));
                check("idle_halt", 64'(fetch_halt), 64'd0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        load_done  = 1'b0;
        reload     = 1'b0;
        fetch_req  = 1'b0;
        ref_n      = 0;
        ref_run    = 1'b0;
        check("rst_load_count", 64'(load_count), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd1);
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_fetch_instr", 64'(fetch_instr), 64'(HALT));
        check("rst_fetch_halt", 64'(fetch_halt), 64'd0);
    endtask

    task automatic load_word(input logic [31:0] w, input bit with_done);
        bit acc;
        acc = !ref_run && (ref_n < DEPTH);
        check("load_ready", 64'(load_ready), 64'(acc));
        load_valid = 1'b1;
        load_data  = w;
        load_done  = with_done;
        @(posedge clk);
        if (acc) begin
            ref_mem[ref_n] = w;
            ref_n++;
            if (ref_n == DEPTH) ref_run = 1'b1;
        end
        if (with_done) ref_run = 1'b1;
        #1;
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic end_load();
        load_done = 1'b1;
        @(posedge clk);
        ref_run = 1'b1;
        #1;
        load_done = 1'b0;
        check("end_load_running", 64'(running), 64'd1);
        check("end_load_count", 64'(load_count), 64'(ref_n));
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(posedge clk);
        if (ref_run) exp_q.push_back(ref_fetch(int'(a)));
        #1;
        fetch_req = 1'b0;
    endtask

    task automatic do_reload(input bit with_fetch);
        reload     = 1'b1;
        fetch_req  = with_fetch;
        fetch_addr = '0;
        @(posedge clk);
        ref_n   = 0;
        ref_run = 1'b0;
        #1;
        reload    = 1'b0;
        fetch_req = 1'b0;
        check("reload_running", 64'(running), 64'd0);
        check("reload_count", 64'(load_count), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_done  = 1'b0;
        reload     = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ref_n      = 0;
        ref_run    = 1'b0;
        do_reset();
        mon_en = 1'b1;

        // Basic load of three words, fetch inside and outside the loaded range.
        load_word(32'h0060_0513, 1'b0);
        load_word(32'h00c0_00ef, 1'b0);
        load_word(32'h00a0_2023, 1'b0);
        end_load();
        fetch(5'd1);
        idle(1);
        fetch(5'd5);
        idle(1);
        fetch(5'd0);
        fetch(5'd1);
        fetch(5'd2);
        fetch(5'd31);
        idle(2);

        // Reload with a same-cycle fetch (dropped), fetches in LOAD ignored, then RUN with no words.
        do_reload(1'b1);
        fetch(5'd0);
        fetch(5'd1);
        idle(1);
        check("reload_ready", 64'(load_ready), 64'd1);
        end_load();
        fetch(5'd0);
        fetch(5'd1);
        fetch(5'd2);
        idle(2);

        // Fill all entries without load_done; one entry holds the halt encoding itself.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word((i == 7) ? HALT : $urandom(), 1'b0);
        end
        check("full_load_ready", 64'(load_ready), 64'd0);
        check("full_running", 64'(running), 64'd1);
        check("full_count", 64'(load_count), 64'(DEPTH));
        load_word(32'h1234_5678, 1'b0);
        check("full_count_hold", 64'(load_count), 64'(DEPTH));
        fetch(5'd0);
        fetch(5'd7);
        fetch(5'd31);
        fetch(5'd17);
        idle(2);

        // load_done coincides with the second accepted word.
        do_reset();
        load_word(32'hdead_0001, 1'b0);
        load_word(32'hbeef_0002, 1'b1);
        check("done_same_count", 64'(load_count), 64'd2);
        check("done_same_running", 64'(running), 64'd1);
        fetch(5'd1);
        fetch(5'd0);
        fetch(5'd2);
        idle(2);

        // Reset mid-load wins over a same-cycle load word and load_done.
        do_reset();
        for (int i = 0; i < 4; i++) load_word(32'h0000_1000 + 32'(i), 1'b0);
        check("mid_count_before", 64'(load_count), 64'd4);
        load_valid = 1'b1;
        load_data  = 32'h5555_aaaa;
        load_done  = 1'b1;
        do_reset();
        load_word(32'h0bad_cafe, 1'b0);
        end_load();
        fetch(5'd0);
        fetch(5'd1);
        fetch(5'd3);
        idle(3);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
- REQ-001 The block SHALL take parameter ADDR_W, default 5, as the fetch address width.
- REQ-002 The block SHALL take parameter DEPTH, default 32, as the number of stored words; DEPTH SHALL be no greater than 2**ADDR_W.
- REQ-003 The block SHALL take parameter DATA_W, default 32, as the instruction width.
- REQ-004 The block SHALL take parameter HALT_WORD, default all-ones of DATA_W, as the halt encoding.
- REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
- REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-007 The block SHALL have port load_valid, input, 1 bit: a loader word is present.
- REQ-008 The block SHALL have port load_data, input, DATA_W bits: the loader word.
- REQ-009 The block SHALL have port load_ready, output, 1 bit: the block accepts a loader word.
- REQ-010 The block SHALL have port load_done, input, 1 bit: pulse ending the load phase.
- REQ-011 The block SHALL have port reload, input, 1 bit: pulse returning the block to the load phase.
- REQ-012 The block SHALL have port fetch_req, input, 1 bit: fetch request.
- REQ-013 The block SHALL have port fetch_addr, input, ADDR_W bits: word address of the fetch.
- REQ-014 The block SHALL have port fetch_valid, output, 1 bit: fetch_instr is valid this cycle.
- REQ-015 The block SHALL have port fetch_instr, output, DATA_W bits: the fetched word.
- REQ-016 The block SHALL have port fetch_halt, output, 1 bit: the fetched word equals HALT_WORD.
- REQ-017 The block SHALL have port running, output, 1 bit: the block is in the RUN state.
- REQ-018 The block SHALL have port load_count, output, ADDR_W+1 bits: number of words loaded.

Function
- REQ-019 The block SHALL implement two states, LOAD and RUN.
- REQ-020 In LOAD, load_ready SHALL be 1 while load_count < DEPTH and 0 otherwise; in RUN, load_ready SHALL be 0.
- REQ-021 A word SHALL be accepted when load_valid && load_ready: it is written at index load_count, its entry is marked written, and load_count increments.
- REQ-022 The block SHALL move LOAD->RUN on the cycle after load_done=1, or on the cycle after the DEPTH-th word is accepted.
- REQ-023 A word accepted in the same cycle as load_done SHALL be stored before the block enters RUN.
- REQ-024 The block SHALL move RUN->LOAD on the cycle after reload=1; reload SHALL clear all written marks and set load_count to 0.
- REQ-025 In RUN, fetch_req=1 SHALL produce fetch_valid=1 exactly one cycle later, with fetch_instr taken from fetch_addr as sampled at request time (1-cycle latency).
- REQ-026 Back-to-back fetches SHALL each be answered, at one result per cycle.
- REQ-027 fetch_instr SHALL be HALT_WORD when fetch_addr >= DEPTH or when the addressed entry is not written.
- REQ-028 fetch_halt SHALL equal (fetch_instr == HALT_WORD) whenever fetch_valid=1, and SHALL be 0 otherwise.
- REQ-029 fetch_req SHALL be ignored in LOAD; a fetch_req in the same cycle as reload SHALL be dropped.
- REQ-030 When fetch_valid=0, fetch_instr SHALL hold HALT_WORD.

Reset
- REQ-031 rst SHALL put the block in LOAD, clear all written marks, and set load_count=0, fetch_valid=0, fetch_halt=0, fetch_instr=HALT_WORD and running=0.
- REQ-032 rst SHALL take priority over load, load_done, reload and fetch in the same cycle; a load in progress SHALL be abandoned.
- REQ-033 Stored data SHALL need no reset, because the written marks mask it.

Structure
- REQ-034 A shared package instr_mem_pkg SHALL hold the state enum (LOAD, RUN) and the default HALT_WORD constant.
- REQ-035 Storage plus the per-entry written bits SHALL be one sub-module, instr_mem_array, with one write port and one registered read port.

Verification
- REQ-036 Reset, load 3 words (0x00600513, 0x00c000ef, 0x00a02023), pulse load_done, fetch addr 1 -> next cycle fetch_valid=1, fetch_instr=0x00c000ef, fetch_halt=0.
- REQ-037 Same load, fetch addr 5 -> fetch_instr=0xFFFFFFFF, fetch_halt=1.
- REQ-038 Load 32 words without load_done -> load_ready drops after the 32nd word, running=1 the next cycle, load_count=32.
- REQ-039 load_done in the same cycle as the 2nd accepted word -> load_count=2, word 1 fetchable in RUN.
- REQ-040 Fetch addresses 0,1,2 on consecutive cycles -> three consecutive fetch_valid cycles with matching data; then reload -> all addresses return HALT_WORD after entering RUN with zero words.
- REQ-041 Assert rst mid-load after 4 words -> the next cycle shows load_count=0, running=0, load_ready=1.
